// File: rtl/mem_stage_if.sv
// Pipeline register types shared by the MEM stage and its neighbours,
// plus the data-memory request/grant/response bus.
package mem_stage_pkg;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic        RegWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        MemToReg;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] mem_data;
    logic [4:0]  rd;
    logic        RegWrite;
    logic        MemToReg;
  } mem_wb_t;

endpackage

interface mem_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, be, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, be, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: owns EX/MEM and MEM/WB, issues word loads/stores on a
// req/gnt + rvalid bus and stalls the front end until each access completes.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  ex_mem_t           ex_mem_next,
  output ex_mem_t           ex_mem_q,
  output mem_wb_t           mem_wb_q,
  output logic              stall,
  mem_stage_if.master       dmem,
  output logic              bus_err,
  output logic              misalign_err,
  output logic              spurious_rsp
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, WAIT_RSP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ex_mem_t          ex_mem_d;
  mem_wb_t          mem_wb_d;
  logic             req;
  logic             acc;
  logic             mis;
  logic             timeout;

  assign acc     = ex_mem_q.MemRead | ex_mem_q.MemWrite;
  assign mis     = acc & (ex_mem_q.alu_result[1:0] != 2'b00);
  assign timeout = (cnt_q == CNT_LIM);

  always_comb begin
    state_d      = state_q;
    stall        = 1'b0;
    req          = 1'b0;
    bus_err      = 1'b0;
    misalign_err = 1'b0;
    mem_wb_d     = '0;
    spurious_rsp = dmem.rvalid && (state_q == IDLE);

    case (state_q)
      IDLE: begin
        if (!acc) begin
          mem_wb_d.alu_result = ex_mem_q.alu_result;
          mem_wb_d.rd         = ex_mem_q.rd;
          mem_wb_d.RegWrite   = ex_mem_q.RegWrite;
          mem_wb_d.MemToReg   = ex_mem_q.MemToReg;
        end else if (mis) begin
          misalign_err = 1'b1;
        end else begin
          req = 1'b1;
          // A granted store is complete; a granted load still needs its response.
          if (dmem.gnt && ex_mem_q.MemWrite) begin
            stall = 1'b0;
          end else if (timeout) begin
            bus_err = 1'b1;
          end else begin
            stall = 1'b1;
            if (dmem.gnt) state_d = WAIT_RSP;
          end
        end
      end
      WAIT_RSP: begin
        if (dmem.rvalid) begin
          mem_wb_d.alu_result = ex_mem_q.alu_result;
          mem_wb_d.mem_data   = dmem.rdata;
          mem_wb_d.rd         = ex_mem_q.rd;
          mem_wb_d.RegWrite   = ex_mem_q.RegWrite;
          mem_wb_d.MemToReg   = ex_mem_q.MemToReg;
          state_d             = IDLE;
        end else if (timeout) begin
          bus_err = 1'b1;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Any unstalled cycle retires the current access, so the counter restarts.
    cnt_d    = stall ? cnt_q + CNT_W'(1) : '0;
    ex_mem_d = stall ? ex_mem_q : ex_mem_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  assign dmem.req   = req;
  assign dmem.we    = ex_mem_q.MemWrite;
  assign dmem.addr  = {ex_mem_q.alu_result[31:2], 2'b00};
  assign dmem.wdata = ex_mem_q.rs2_data;
  assign dmem.be    = 4'hF;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage; a negedge monitor checks writebacks, bus
// handshakes and error pulses against queues filled by the stimulus.
module tb_mem_stage;
  import mem_stage_pkg::*;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_exp_t;

  logic    clk = 1'b0;
  logic    rst_n;
  ex_mem_t ex_mem_next;
  ex_mem_t ex_mem_q;
  mem_wb_t mem_wb_q;
  logic    stall, bus_err, misalign_err, spurious_rsp;

  mem_stage_if bus_if ();

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_mem_next  (ex_mem_next),
    .ex_mem_q     (ex_mem_q),
    .mem_wb_q     (mem_wb_q),
    .stall        (stall),
    .dmem         (bus_if.master),
    .bus_err      (bus_err),
    .misalign_err (misalign_err),
    .spurious_rsp (spurious_rsp)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int stall_cnt;
  int req_cnt;

  mem_wb_t    wb_q[$];
  bus_exp_t   bx_q[$];
  logic [2:0] err_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic ex_mem_t mk(input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                                 input logic rw, input logic mr, input logic mw, input logic m2r);
    ex_mem_t e;
    e.alu_result = alu; e.rs2_data = rs2; e.rd = rd;
    e.RegWrite = rw; e.MemRead = mr; e.MemWrite = mw; e.MemToReg = m2r;
    return e;
  endfunction

  function automatic mem_wb_t wb(input logic [31:0] alu, input logic [31:0] md, input logic [4:0] rd,
                                 input logic m2r);
    mem_wb_t w;
    w.alu_result = alu; w.mem_data = md; w.rd = rd; w.RegWrite = 1'b1; w.MemToReg = m2r;
    return w;
  endfunction

  // One bus cycle: drive responses, tally stall/req, cross the edge.
  task automatic cyc(input logic g, input logic r, input logic [31:0] d);
    bus_if.gnt = g; bus_if.rvalid = r; bus_if.rdata = d;
    #1;
    stall_cnt += int'(stall);
    req_cnt   += int'(bus_if.req);
    @(posedge clk); #1;
    bus_if.gnt = 1'b0; bus_if.rvalid = 1'b0; bus_if.rdata = '0;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (mem_wb_q.RegWrite) begin
        if (wb_q.size() == 0) chk("wb_unexpected", {59'd0, mem_wb_q.rd}, 64'd0);
        else begin
          mem_wb_t e;
          e = wb_q.pop_front();
          chk("wb_rd", 64'(mem_wb_q.rd), 64'(e.rd));
          chk("wb_alu", 64'(mem_wb_q.alu_result), 64'(e.alu_result));
          chk("wb_mem", 64'(mem_wb_q.mem_data), 64'(e.mem_data));
          chk("wb_m2r", 64'(mem_wb_q.MemToReg), 64'(e.MemToReg));
          $display("wb   rd=%0d alu=%h mem=%h", mem_wb_q.rd, mem_wb_q.alu_result, mem_wb_q.mem_data);
        end
      end
      if (bus_if.req && bus_if.gnt) begin
        if (bx_q.size() == 0) chk("bus_unexpected", 64'(bus_if.addr), 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          bus_exp_t b;
          b = bx_q.pop_front();
          chk("bus_addr", 64'(bus_if.addr), 64'(b.addr));
          chk("bus_wdata", 64'(bus_if.wdata), 64'(b.wdata));
          chk("bus_we_be", 64'({bus_if.we, bus_if.be}), 64'({b.we, 4'hF}));
          $display("bus  we=%0d addr=%h wdata=%h", bus_if.we, bus_if.addr, bus_if.wdata);
        end
      end
      if (bus_err || misalign_err || spurious_rsp) begin
        if (err_q.size() == 0) chk("err_unexpected", 64'({bus_err, misalign_err, spurious_rsp}), 64'd0);
        else begin
          logic [2:0] e3;
          e3 = err_q.pop_front();
          chk("err_flags", 64'({bus_err, misalign_err, spurious_rsp}), 64'(e3));
          $display("err  bus=%0d mis=%0d spur=%0d", bus_err, misalign_err, spurious_rsp);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    ex_mem_next = '0;
    bus_if.gnt = 1'b0; bus_if.rvalid = 1'b0; bus_if.rdata = '0;
    stall_cnt = 0; req_cnt = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_exmem", 64'(ex_mem_q), 64'd0);
    chk("rst_memwb", 64'(mem_wb_q), 64'd0);
    chk("rst_outs", 64'({stall, bus_if.req, bus_if.we, bus_err, misalign_err, spurious_rsp}), 64'd0);
    chk("rst_be", 64'(bus_if.be), 64'hF);
    rst_n = 1'b1;

    // ALU op retires one cycle after entering EX/MEM, no stall.
    ex_mem_next = mk(32'h10, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    wb_q.push_back(wb(32'h10, 32'h0, 5'd5, 1'b0));
    cyc(1'b0, 1'b0, '0);
    ex_mem_next = '0;
    stall_cnt = 0;
    cyc(1'b0, 1'b0, '0);
    chk("alu_stall", 64'(stall_cnt), 64'd0);

    // Load 0x100, immediate gnt, rvalid three cycles later.
    ex_mem_next = mk(32'h100, 32'h77, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, '0);
    ex_mem_next = mk(32'h55, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    bx_q.push_back('{1'b0, 32'h100, 32'h77});
    wb_q.push_back(wb(32'h100, 32'hCAFE_F00D, 5'd7, 1'b1));
    wb_q.push_back(wb(32'h55, 32'h0, 5'd9, 1'b0));
    stall_cnt = 0; req_cnt = 0;
    cyc(1'b1, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 32'hCAFE_F00D);
    chk("ld_stall", 64'(stall_cnt), 64'd3);
    chk("ld_req", 64'(req_cnt), 64'd1);
    chk("ld_next_rd", 64'(ex_mem_q.rd), 64'd9);
    ex_mem_next = '0;
    cyc(1'b0, 1'b0, '0);

    // Store 0x200 with gnt delayed two cycles.
    ex_mem_next = mk(32'h200, 32'h1234, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, '0);
    ex_mem_next = '0;
    bx_q.push_back('{1'b1, 32'h200, 32'h1234});
    stall_cnt = 0; req_cnt = 0;
    cyc(1'b0, 1'b0, '0);
    chk("st_addr_hold", 64'(bus_if.addr), 64'h200);
    cyc(1'b0, 1'b0, '0);
    chk("st_wdata_hold", 64'(bus_if.wdata), 64'h1234);
    cyc(1'b1, 1'b0, '0);
    chk("st_stall", 64'(stall_cnt), 64'd2);
    chk("st_req", 64'(req_cnt), 64'd3);

    // MemRead and MemWrite together behave as a store.
    ex_mem_next = mk(32'h300, 32'hA5A5, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, '0);
    ex_mem_next = '0;
    bx_q.push_back('{1'b1, 32'h300, 32'hA5A5});
    stall_cnt = 0;
    cyc(1'b1, 1'b0, '0);
    chk("both_stall", 64'(stall_cnt), 64'd0);
    chk("both_regwrite", 64'(mem_wb_q.RegWrite), 64'd0);

    // Misaligned load: no request, one error pulse, bubble.
    ex_mem_next = mk(32'h102, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, '0);
    ex_mem_next = '0;
    err_q.push_back(3'b010);
    stall_cnt = 0; req_cnt = 0;
    cyc(1'b0, 1'b0, '0);
    chk("mis_stall", 64'(stall_cnt), 64'd0);
    chk("mis_req", 64'(req_cnt), 64'd0);
    chk("mis_regwrite", 64'(mem_wb_q.RegWrite), 64'd0);

    // rvalid in the gnt cycle is spurious; the real response follows.
    ex_mem_next = mk(32'h180, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, '0);
    ex_mem_next = '0;
    bx_q.push_back('{1'b0, 32'h180, 32'h0});
    err_q.push_back(3'b001);
    wb_q.push_back(wb(32'h180, 32'hBEEF, 5'd10, 1'b1));
    stall_cnt = 0;
    cyc(1'b1, 1'b1, 32'hDEAD);
    cyc(1'b0, 1'b1, 32'hBEEF);
    chk("sp_stall", 64'(stall_cnt), 64'd1);
    cyc(1'b0, 1'b0, '0);

    // Timeout: load granted, no response; abort on 4th incomplete cycle.
    ex_mem_next = mk(32'h40, 32'h9, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, '0);
    ex_mem_next = '0;
    bx_q.push_back('{1'b0, 32'h40, 32'h9});
    err_q.push_back(3'b100);
    stall_cnt = 0;
    cyc(1'b1, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    chk("to_stall", 64'(stall_cnt), 64'd3);
    chk("to_exmem", 64'(ex_mem_q), 64'd0);
    chk("to_idle", 64'({stall, bus_if.req}), 64'd0);
    err_q.push_back(3'b001);
    cyc(1'b0, 1'b1, 32'h1111);

    // Reset during WAIT_RSP abandons the access silently.
    ex_mem_next = mk(32'h80, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, '0);
    ex_mem_next = '0;
    bx_q.push_back('{1'b0, 32'h80, 32'h0});
    cyc(1'b1, 1'b0, '0);
    rst_n = 1'b0;
    cyc(1'b0, 1'b0, '0);
    chk("rst2_memwb", 64'(mem_wb_q), 64'd0);
    chk("rst2_exmem", 64'(ex_mem_q), 64'd0);
    chk("rst2_outs", 64'({stall, bus_err, bus_if.req}), 64'd0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);

    chk("left_wb", 64'(wb_q.size()), 64'd0);
    chk("left_bus", 64'(bx_q.size()), 64'd0);
    chk("left_err", 64'(err_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
